digit_entry: RTL and testbench
==============================

Name: digit_entry

Overview:
- Upstream user-input stage for the 4-digit, 2-bit-per-digit seven-segment scan driver.
- Debounces three pushbuttons (select, increment, commit) and lets the user edit a shadow copy of the 8-bit display word, one digit at a time.
- Presents that word as disp_data, which connects directly to the scan driver's 8-bit data input.
- Holds the last committed value in data_out for the rest of the design.

Parameters:
- DB_CYCLES, 50000: consecutive stable synchronized samples required before a button level is accepted (minimum 2).
- DIGITS, 4: number of digits; fixed to match the scan driver.
- DIGIT_W, 2: bits per digit; digit k occupies bits [k*DIGIT_W+1 : k*DIGIT_W].
- TIMEOUT_CYCLES, 2^24: edit-abandon interval; used only with EDIT_TIMEOUT_EN.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- btn_sel  input  1  raw select button, asynchronous to clk.
- btn_inc  input  1  raw increment button, asynchronous to clk.
- btn_ok  input  1  raw commit button, asynchronous to clk.
- disp_data  output  8  word to display: shadow while editing, data_out otherwise.
- data_out  output  8  last committed word.
- editing  output  1  high in EDIT state.
- cursor  output  2  index of the digit being edited.
- update  output  1  one-cycle pulse on the cycle data_out changes.

Behaviour:
- Reset (asynchronous, takes effect immediately, independent of clk):
  - data_out=0, shadow=0, cursor=0, state=IDLE, update=0.
  - All synchronizer flops, stable levels and debounce counters clear to 0.
  - Asserting rst mid-edit discards shadow; no commit occurs.
- Per-button debounce:
  - 2-flop synchronizer produces s.
  - If s==stable: cnt<=0.
  - Else if cnt==DB_CYCLES-1: stable<=s, cnt<=0.
  - Else: cnt<=cnt+1.
  - press = stable & ~stable_d: one cycle per accepted rising level; release generates nothing.
  - Bounce shorter than DB_CYCLES consecutive cycles is ignored.
  - cnt width = clog2(DB_CYCLES).
- Latency: raw pin high at edge 0 → press high after edge 2+DB_CYCLES → FSM registers update on the following edge.
- FSM states IDLE, EDIT. Press priority ok > sel > inc; lower-priority presses in the same cycle are dropped.
- In IDLE:
  - sel: shadow<=data_out, cursor<=0, go to EDIT.
  - inc, ok: ignored.
- In EDIT:
  - ok: data_out<=shadow, update<=1 for one cycle, go to IDLE; cursor holds.
  - sel: cursor<=cursor+1, wrapping 3→0.
  - inc: shadow digit[cursor]<=digit+1 mod 4 (3→0); other digits unchanged.
- A commit with shadow equal to data_out still pulses update.
- disp_data is combinational from registered state and changes the same cycle the state changes.
- All outputs are driven from flops or a 2:1 mux of flops; no combinational path from button inputs.

Optional Feature:
- Macro EDIT_TIMEOUT_EN.
- Defined:
  - An idle counter clears on entry to EDIT and on any accepted press.
  - The counter increments each cycle in EDIT.
  - On reaching TIMEOUT_CYCLES-1 the block returns to IDLE without commit: shadow discarded, no update pulse, data_out unchanged.
  - A press arriving on the expiry cycle takes precedence over the timeout.
- Undefined: no counter; EDIT persists until ok or reset.

Decomposition:
- Package digit_entry_pkg:
  - state encoding (IDLE=0, EDIT=1);
  - DIGITS, DIGIT_W, and derived word width 8;
  - press priority order constants.
- Sub-module btn_debounce (parameter DB_CYCLES; ports clk, rst, raw, level, press), instantiated three times.
- FSM and shadow register stay in the top module.

Test Plan:
1. DB_CYCLES=4; assert rst asynchronously between clock edges during EDIT → editing=0, data_out=8'h00, cursor=0 before the next edge; no update pulse.
2. DB_CYCLES=4; btn_inc high 3 cycles then low, repeated → no press and shadow unchanged; hold high 10 cycles → exactly one increment.
3. Press sequence sel, inc ×3, sel, inc, ok → disp_data tracks shadow; data_out=8'h07; update high exactly one cycle; editing=0 afterwards.
4. Wrap-around: in EDIT, inc ×5 on digit 0 → digit 0 = 1; sel ×4 → cursor returns to 0.
5. Simultaneous: in EDIT with shadow digit 0 = 2, ok and inc accepted the same cycle → data_out[1:0]=2 and no increment; sel+inc together → cursor advances, no increment.
6. With EDIT_TIMEOUT_EN, TIMEOUT_CYCLES=32, data_out=8'h07: sel, inc, then idle 40 cycles → editing drops at cycle 32 after the last press; data_out stays 8'h07; update never pulses.

Source files
------------

// File: rtl/digit_entry_pkg.sv
// Shared types and constants for the digit_entry user-input block.
// State encoding, word geometry, press priority order and a digit-bump helper.
package digit_entry_pkg;

  localparam int DIGITS  = 4;
  localparam int DIGIT_W = 2;
  localparam int WORD_W  = DIGITS * DIGIT_W;
  localparam int CUR_W   = $clog2(DIGITS);

  typedef enum logic {
    IDLE = 1'b0,
    EDIT = 1'b1
  } state_t;

  // Bit positions in the press vector; a lower index wins over a higher one.
  localparam int PRIO_OK  = 0;
  localparam int PRIO_SEL = 1;
  localparam int PRIO_INC = 2;
  localparam int NUM_BTN  = 3;

  function automatic logic [WORD_W-1:0] bump_digit(input logic [WORD_W-1:0] w,
                                                   input logic [CUR_W-1:0]  idx);
    logic [WORD_W-1:0] r;
    r = w;
    for (int k = 0; k < DIGITS; k++)
      if (k == int'(idx))
        r[k*DIGIT_W +: DIGIT_W] = w[k*DIGIT_W +: DIGIT_W] + 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/digit_entry_btn_debounce.sv
// Two-flop synchronizer plus stability-count debouncer for one raw button.
// press pulses for one cycle on each accepted rising level.
module btn_debounce #(
  parameter int DB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DB_CYCLES);

  logic [1:0]    sync_q;
  logic          stable_q, stable_d, stable_dly_q;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    stable_d = stable_q;
    cnt_d    = cnt_q;
    if (sync_q[1] == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
      stable_d = sync_q[1];
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q       <= '0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync_q       <= {sync_q[0], raw};
      stable_q     <= stable_d;
      stable_dly_q <= stable_q;
      cnt_q        <= cnt_d;
    end
  end

  assign level = stable_q;
  assign press = stable_q & ~stable_dly_q;

endmodule

// File: rtl/digit_entry.sv
// Button-driven editor for the 8-bit display word feeding the scan driver.
// Optional edit-abandon timeout is enabled by defining EDIT_TIMEOUT_EN.
module digit_entry
  import digit_entry_pkg::*;
#(
  parameter int DB_CYCLES      = 50000,
  parameter int TIMEOUT_CYCLES = 1 << 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_sel,
  input  logic              btn_inc,
  input  logic              btn_ok,
  output logic [WORD_W-1:0] disp_data,
  output logic [WORD_W-1:0] data_out,
  output logic              editing,
  output logic [CUR_W-1:0]  cursor,
  output logic              update
);

  logic [NUM_BTN-1:0] raw, prs, lvl;
  state_t             state_q, state_d;
  logic [WORD_W-1:0]  shadow_q, shadow_d, data_out_q, data_out_d;
  logic [CUR_W-1:0]   cursor_q, cursor_d;
  logic               update_q, update_d;

  always_comb begin
    raw           = '0;
    raw[PRIO_OK]  = btn_ok;
    raw[PRIO_SEL] = btn_sel;
    raw[PRIO_INC] = btn_inc;
  end

  for (genvar b = 0; b < NUM_BTN; b++) begin : g_btn
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk   (clk),
      .rst   (rst),
      .raw   (raw[b]),
      .level (lvl[b]),
      .press (prs[b])
    );
  end

`ifdef EDIT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    data_out_d = data_out_q;
    cursor_d   = cursor_q;
    update_d   = 1'b0;
    case (state_q)
      IDLE: begin
        // ok outranks sel even though it has no effect here.
        if (!prs[PRIO_OK] && prs[PRIO_SEL]) begin
          shadow_d = data_out_q;
          cursor_d = '0;
          state_d  = EDIT;
        end
      end
      EDIT: begin
        if (prs[PRIO_OK]) begin
          data_out_d = shadow_q;
          update_d   = 1'b1;
          state_d    = IDLE;
        end else if (prs[PRIO_SEL]) begin
          cursor_d = cursor_q + 1'b1;
        end else if (prs[PRIO_INC]) begin
          shadow_d = bump_digit(shadow_q, cursor_q);
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef EDIT_TIMEOUT_EN
    tmo_d = '0;
    if (state_q == EDIT && prs == '0) begin
      if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) state_d = IDLE;
      else                                  tmo_d   = tmo_q + 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shadow_q   <= '0;
      data_out_q <= '0;
      cursor_q   <= '0;
      update_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      data_out_q <= data_out_d;
      cursor_q   <= cursor_d;
      update_q   <= update_d;
    end
  end

`ifdef EDIT_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) tmo_q <= '0;
    else     tmo_q <= tmo_d;
  end
`endif

  assign editing   = (state_q == EDIT);
  assign disp_data = editing ? shadow_q : data_out_q;
  assign data_out  = data_out_q;
  assign cursor    = cursor_q;
  assign update    = update_q;

endmodule

// File: tb/tb_digit_entry.sv
// Directed bench for digit_entry with a short debounce interval.
// The timeout section only runs when EDIT_TIMEOUT_EN is defined.
module tb_digit_entry;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_sel = 1'b0, btn_inc = 1'b0, btn_ok = 1'b0;
  logic [7:0] disp_data, data_out;
  logic       editing, update;
  logic [1:0] cursor;

  int n_chk  = 0;
  int n_fail = 0;
  int upd_cnt = 0;

  digit_entry #(.DB_CYCLES(4), .TIMEOUT_CYCLES(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_sel   (btn_sel),
    .btn_inc   (btn_inc),
    .btn_ok    (btn_ok),
    .disp_data (disp_data),
    .data_out  (data_out),
    .editing   (editing),
    .cursor    (cursor),
    .update    (update)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (update) upd_cnt++;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // b: 0=ok 1=sel 2=inc, bit mask so several buttons can go together
  task automatic push(input logic [2:0] m);
    @(negedge clk);
    btn_ok = m[0]; btn_sel = m[1]; btn_inc = m[2];
    repeat (10) @(negedge clk);
    btn_ok = 1'b0; btn_sel = 1'b0; btn_inc = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int n;
    // reset state
    do_reset();
    check("rst_editing", {7'd0, editing}, 8'h00);
    check("rst_data_out", data_out, 8'h00);
    check("rst_disp", disp_data, 8'h00);
    check("rst_cursor", {6'd0, cursor}, 8'h00);
    check("rst_update", {7'd0, update}, 8'h00);

    // 1: asynchronous reset mid-edit
    push(3'b010);
    push(3'b100);
    check("t1_edit", {7'd0, editing}, 8'h01);
    check("t1_disp", disp_data, 8'h01);
    upd_cnt = 0;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("t1_async_editing", {7'd0, editing}, 8'h00);
    check("t1_async_data", data_out, 8'h00);
    check("t1_async_disp", disp_data, 8'h00);
    check("t1_async_cursor", {6'd0, cursor}, 8'h00);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    check("t1_no_update", upd_cnt[7:0], 8'h00);

    // 2: bounce shorter than the debounce interval is ignored
    push(3'b010);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); btn_inc = 1'b1;
      repeat (3) @(negedge clk); btn_inc = 1'b0;
      repeat (3) @(negedge clk);
    end
    repeat (8) @(negedge clk);
    check("t2_bounce", disp_data, 8'h00);
    @(negedge clk); btn_inc = 1'b1;
    repeat (10) @(negedge clk); btn_inc = 1'b0;
    repeat (10) @(negedge clk);
    check("t2_one_inc", disp_data, 8'h01);

    // 3: edit sequence and commit
    do_reset();
    push(3'b010);
    check("t3_edit", {7'd0, editing}, 8'h01);
    push(3'b100); check("t3_inc1", disp_data, 8'h01);
    push(3'b100); check("t3_inc2", disp_data, 8'h02);
    push(3'b100); check("t3_inc3", disp_data, 8'h03);
    push(3'b010); check("t3_cursor1", {6'd0, cursor}, 8'h01);
    push(3'b100); check("t3_inc_d1", disp_data, 8'h07);
    check("t3_data_hold", data_out, 8'h00);
    upd_cnt = 0;
    push(3'b001);
    check("t3_data_out", data_out, 8'h07);
    check("t3_update_once", upd_cnt[7:0], 8'h01);
    check("t3_idle", {7'd0, editing}, 8'h00);
    check("t3_cursor_hold", {6'd0, cursor}, 8'h01);

    // 4: digit and cursor wrap-around
    do_reset();
    push(3'b010);
    for (int i = 0; i < 5; i++) push(3'b100);
    check("t4_digit_wrap", disp_data, 8'h01);
    for (int i = 1; i <= 4; i++) begin
      push(3'b010);
      check("t4_cursor", {6'd0, cursor}, 8'((i % 4)));
    end
    push(3'b001);
    check("t4_commit", data_out, 8'h01);

    // 5: simultaneous presses follow priority
    push(3'b010);
    push(3'b100);
    check("t5_pre", disp_data, 8'h02);
    upd_cnt = 0;
    push(3'b101);
    check("t5_ok_wins", data_out, 8'h02);
    check("t5_ok_update", upd_cnt[7:0], 8'h01);
    check("t5_ok_idle", {7'd0, editing}, 8'h00);
    push(3'b010);
    push(3'b110);
    check("t5_sel_wins_cur", {6'd0, cursor}, 8'h01);
    check("t5_sel_wins_disp", disp_data, 8'h02);

    // idle ignores inc and ok
    do_reset();
    push(3'b100);
    push(3'b001);
    check("idle_ignore_edit", {7'd0, editing}, 8'h00);
    check("idle_ignore_data", data_out, 8'h00);

`ifdef EDIT_TIMEOUT_EN
    // 6: edit abandoned after the idle interval
    push(3'b010); push(3'b100); push(3'b100); push(3'b100);
    push(3'b010); push(3'b100); push(3'b001);
    check("t6_pre", data_out, 8'h07);
    upd_cnt = 0;
    push(3'b010);
    @(negedge clk); btn_inc = 1'b1;
    n = 0;
    while (disp_data != 8'h04 && n < 50) begin @(negedge clk); n++; end
    check("t6_inc_seen", disp_data, 8'h04);
    btn_inc = 1'b0;
    n = 0;
    while (editing && n < 60) begin @(negedge clk); n++; end
    check("t6_timeout_cycles", n[7:0], 8'd32);
    check("t6_editing", {7'd0, editing}, 8'h00);
    check("t6_data_kept", data_out, 8'h07);
    check("t6_no_update", upd_cnt[7:0], 8'h00);
`else
    // without the timeout, EDIT persists indefinitely
    push(3'b010);
    repeat (200) @(negedge clk);
    check("no_timeout", {7'd0, editing}, 8'h01);
    n = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
